// File: rtl/commit_redirect_pkg.sv
// Shared types for the WB commit/redirect controller: FSM states, retire
// events and the exception code used for interrupts.
package commit_redirect_pkg;

   typedef enum logic [1:0] {
      CS_RUN,
      CS_FLUSH,
      CS_IDLE
   } CommitState;

   typedef enum logic [2:0] {
      EV_NONE,
      EV_INT,
      EV_EXC,
      EV_ERTN,
      EV_REFETCH,
      EV_IDLE
   } CommitEvt;

   localparam int ECODE_INT = 0;

endpackage

// File: rtl/commit_redirect_if.sv
// WB-side bundle of the commit/redirect controller: retiring-instruction
// attributes and CSR values in, flush/redirect/CSR strobes out.
interface commit_redirect_if #(
   parameter int PC_W    = 32,
   parameter int ECODE_W = 6
);
   logic               wb_valid;
   logic [PC_W-1:0]    wb_pc;
   logic               wb_exc;
   logic [ECODE_W-1:0] wb_ecode;
   logic [PC_W-1:0]    wb_badv;
   logic               wb_ertn;
   logic               wb_fetch_again;
   logic               wb_idle;
   logic               int_pending;
   logic [PC_W-1:0]    eentry;
   logic [PC_W-1:0]    era;

   logic               wb_is_exc;
   logic               wb_is_ertn;
   logic               wb_is_fetch_again;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic               csr_exc_we;
   logic [ECODE_W-1:0] csr_ecode;
   logic [PC_W-1:0]    csr_era_wd;
   logic [PC_W-1:0]    csr_badv_wd;
   logic               csr_ertn_we;
   logic               commit_stall;

   modport master (
      output wb_valid, wb_pc, wb_exc, wb_ecode, wb_badv, wb_ertn,
             wb_fetch_again, wb_idle, int_pending, eentry, era,
      input  wb_is_exc, wb_is_ertn, wb_is_fetch_again, redirect_valid,
             redirect_pc, csr_exc_we, csr_ecode, csr_era_wd, csr_badv_wd,
             csr_ertn_we, commit_stall
   );

   modport slave (
      input  wb_valid, wb_pc, wb_exc, wb_ecode, wb_badv, wb_ertn,
             wb_fetch_again, wb_idle, int_pending, eentry, era,
      output wb_is_exc, wb_is_ertn, wb_is_fetch_again, redirect_valid,
             redirect_pc, csr_exc_we, csr_ecode, csr_era_wd, csr_badv_wd,
             csr_ertn_we, commit_stall
   );
endinterface

// File: rtl/commit_prio.sv
// Priority encoder for the instruction retiring in WB:
// interrupt > exception > ertn > fetch-again > idle.
module commit_prio
   import commit_redirect_pkg::*;
(
   input  logic     wb_valid,
   input  logic     int_pending,
   input  logic     wb_exc,
   input  logic     wb_ertn,
   input  logic     wb_fetch_again,
   input  logic     wb_idle,
   output CommitEvt evt
);

   always_comb begin
      evt = EV_NONE;
      if (wb_valid) begin
         if (int_pending)         evt = EV_INT;
         else if (wb_exc)         evt = EV_EXC;
         else if (wb_ertn)        evt = EV_ERTN;
         else if (wb_fetch_again) evt = EV_REFETCH;
         else if (wb_idle)        evt = EV_IDLE;
      end
   end

endmodule

// File: rtl/commit_redirect.sv
// WB commit/redirect controller: turns the retiring instruction's event into
// one-cycle flush pulses, a fetch redirect and CSR trap-state strobes.
module commit_redirect
   import commit_redirect_pkg::*;
#(
   parameter int PC_W    = 32,
   parameter int ECODE_W = 6
) (
   input logic               clk,
   input logic               rstn,
   commit_redirect_if.slave  bus
);

   CommitState         state_q, state_d;
   CommitEvt           evt_p0;
   logic [PC_W-1:0]    idle_pc_q;

   logic               is_exc_p0, is_ertn_p0, is_fa_p0, redir_p0;
   logic               exc_we_p0, ertn_we_p0, stall_p0;
   logic [PC_W-1:0]    redir_pc_p0, era_wd_p0, badv_wd_p0;
   logic [ECODE_W-1:0] ecode_p0;

   logic               is_exc_p1, is_ertn_p1, is_fa_p1, redir_p1;
   logic               exc_we_p1, ertn_we_p1, stall_p1;
   logic [PC_W-1:0]    redir_pc_p1, era_wd_p1, badv_wd_p1;
   logic [ECODE_W-1:0] ecode_p1;

   function automatic logic [PC_W-1:0] inc_pc(input logic [PC_W-1:0] pc);
      return pc + PC_W'(4);
   endfunction

   commit_prio u_prio (
      .wb_valid       (bus.wb_valid),
      .int_pending    (bus.int_pending),
      .wb_exc         (bus.wb_exc),
      .wb_ertn        (bus.wb_ertn),
      .wb_fetch_again (bus.wb_fetch_again),
      .wb_idle        (bus.wb_idle),
      .evt            (evt_p0)
   );

   // Stage p0: event resolution and next-state
   always_comb begin
      state_d     = state_q;
      is_exc_p0   = 1'b0;
      is_ertn_p0  = 1'b0;
      is_fa_p0    = 1'b0;
      redir_p0    = 1'b0;
      exc_we_p0   = 1'b0;
      ertn_we_p0  = 1'b0;
      stall_p0    = 1'b0;
      redir_pc_p0 = '0;
      era_wd_p0   = '0;
      badv_wd_p0  = '0;
      ecode_p0    = '0;
      case (state_q)
         CS_RUN: begin
            case (evt_p0)
               EV_INT: begin
                  state_d     = CS_FLUSH;
                  is_exc_p0   = 1'b1;
                  redir_p0    = 1'b1;
                  exc_we_p0   = 1'b1;
                  redir_pc_p0 = bus.eentry;
                  era_wd_p0   = bus.wb_pc;
                  ecode_p0    = ECODE_W'(ECODE_INT);
               end
               EV_EXC: begin
                  state_d     = CS_FLUSH;
                  is_exc_p0   = 1'b1;
                  redir_p0    = 1'b1;
                  exc_we_p0   = 1'b1;
                  redir_pc_p0 = bus.eentry;
                  era_wd_p0   = bus.wb_pc;
                  badv_wd_p0  = bus.wb_badv;
                  ecode_p0    = bus.wb_ecode;
               end
               EV_ERTN: begin
                  state_d     = CS_FLUSH;
                  is_ertn_p0  = 1'b1;
                  redir_p0    = 1'b1;
                  ertn_we_p0  = 1'b1;
                  redir_pc_p0 = bus.era;
               end
               EV_REFETCH: begin
                  state_d     = CS_FLUSH;
                  is_fa_p0    = 1'b1;
                  redir_p0    = 1'b1;
                  redir_pc_p0 = inc_pc(bus.wb_pc);
               end
               EV_IDLE: begin
                  state_d  = CS_IDLE;
                  stall_p0 = 1'b1;
               end
               default: ;
            endcase
         end
         CS_IDLE: begin
            // Interrupt wakes the core; it resumes after the idle instruction
            if (bus.int_pending) begin
               state_d     = CS_FLUSH;
               is_exc_p0   = 1'b1;
               redir_p0    = 1'b1;
               exc_we_p0   = 1'b1;
               redir_pc_p0 = bus.eentry;
               era_wd_p0   = inc_pc(idle_pc_q);
               ecode_p0    = ECODE_W'(ECODE_INT);
            end else begin
               stall_p0 = 1'b1;
            end
         end
         default: state_d = CS_RUN;
      endcase
   end

   // Stage p1: registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= CS_RUN;
         idle_pc_q   <= '0;
         is_exc_p1   <= 1'b0;
         is_ertn_p1  <= 1'b0;
         is_fa_p1    <= 1'b0;
         redir_p1    <= 1'b0;
         exc_we_p1   <= 1'b0;
         ertn_we_p1  <= 1'b0;
         stall_p1    <= 1'b0;
         redir_pc_p1 <= '0;
         era_wd_p1   <= '0;
         badv_wd_p1  <= '0;
         ecode_p1    <= '0;
      end else begin
         state_q     <= state_d;
         if (state_q == CS_RUN && evt_p0 == EV_IDLE) idle_pc_q <= bus.wb_pc;
         is_exc_p1   <= is_exc_p0;
         is_ertn_p1  <= is_ertn_p0;
         is_fa_p1    <= is_fa_p0;
         redir_p1    <= redir_p0;
         exc_we_p1   <= exc_we_p0;
         ertn_we_p1  <= ertn_we_p0;
         stall_p1    <= stall_p0;
         redir_pc_p1 <= redir_pc_p0;
         era_wd_p1   <= era_wd_p0;
         badv_wd_p1  <= badv_wd_p0;
         ecode_p1    <= ecode_p0;
      end
   end

   assign bus.wb_is_exc         = is_exc_p1;
   assign bus.wb_is_ertn        = is_ertn_p1;
   assign bus.wb_is_fetch_again = is_fa_p1;
   assign bus.redirect_valid    = redir_p1;
   assign bus.redirect_pc       = redir_pc_p1;
   assign bus.csr_exc_we        = exc_we_p1;
   assign bus.csr_ecode         = ecode_p1;
   assign bus.csr_era_wd        = era_wd_p1;
   assign bus.csr_badv_wd       = badv_wd_p1;
   assign bus.csr_ertn_we       = ertn_we_p1;
   assign bus.commit_stall      = stall_p1;

endmodule
